// File: rtl/wrr_input_arbiter_pkg.sv
// Shared defaults and FSM encoding for the weighted round-robin input arbiter.
package wrr_input_arbiter_pkg;
    localparam int DATA_WIDTH_DEF   = 64;
    localparam int CTRL_WIDTH_DEF   = DATA_WIDTH_DEF / 8;
    localparam int NUM_QUEUES_DEF   = 8;
    localparam int WEIGHT_WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } fsm_state_t;
endpackage

// File: rtl/wrr_input_arbiter_rr_next_sel.sv
// Rotating search: first eligible index after cur, wrapping, with cur itself checked last.
module rr_next_sel #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] cur,
    output logic [IW-1:0] next,
    output logic          found
);
    logic [IW-1:0] idx;

    // Scan farthest offset first so the nearest eligible index overwrites the rest.
    always_comb begin
        next  = cur;
        found = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(cur) + k) % N);
            if (elig[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wrr_input_arbiter.sv
// Weighted round-robin arbiter over FWFT input FIFOs; grants switch only between packets.
module wrr_input_arbiter
    import wrr_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_QUEUES   = NUM_QUEUES_DEF,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
    input  logic [NUM_QUEUES-1:0]              in_empty,
    output logic [NUM_QUEUES-1:0]              in_rd_en,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
    output logic [QW-1:0]                      cur_queue,
    output logic                               state,
    output logic                               eop
);
    logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0]   data_arr;
    logic [NUM_QUEUES-1:0][CTRL_WIDTH-1:0]   ctrl_arr;
    logic [NUM_QUEUES-1:0][WEIGHT_WIDTH-1:0] w_arr;
    logic [NUM_QUEUES-1:0]                   elig;

    fsm_state_t              fsm_q, fsm_d;
    logic                    in_hdr_q, in_hdr_d;
    logic [WEIGHT_WIDTH-1:0] credit_q;
    logic [QW-1:0]           next_q;
    logic                    next_found;
    logic [CTRL_WIDTH-1:0]   head_ctrl;
    logic                    head_empty, advance, pop, eop_pop;

    assign data_arr = in_data;
    assign ctrl_arr = in_ctrl;
    assign w_arr    = weights;

    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++)
            elig[i] = !in_empty[i] && (w_arr[i] != '0);
    end

    rr_next_sel #(.N(NUM_QUEUES), .IW(QW)) u_next_sel (
        .elig  (elig),
        .cur   (cur_queue),
        .next  (next_q),
        .found (next_found)
    );

    assign head_ctrl  = ctrl_arr[cur_queue];
    assign head_empty = in_empty[cur_queue];

    // A packet has started once any header word is popped, even though the FSM stays IDLE.
    assign advance = (fsm_q == IDLE) && !in_hdr_q && ((credit_q == '0) || head_empty);
    assign pop     = !reset && !advance && !head_empty && out_rdy && (w_arr[cur_queue] != '0);
    assign eop_pop = pop && (fsm_q == PKT) && (head_ctrl != '0);

    always_comb begin
        in_rd_en            = '0;
        in_rd_en[cur_queue] = pop;
    end

    always_comb begin
        fsm_d    = fsm_q;
        in_hdr_d = in_hdr_q;
        if (pop) begin
            case (fsm_q)
                IDLE: begin
                    if (head_ctrl == '0) begin
                        fsm_d    = PKT;
                        in_hdr_d = 1'b0;
                    end else begin
                        in_hdr_d = 1'b1;
                    end
                end
                PKT:     if (head_ctrl != '0) fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= IDLE;
            in_hdr_q  <= 1'b0;
            cur_queue <= '0;
            credit_q  <= '0;
            out_wr    <= 1'b0;
            eop       <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else begin
            fsm_q    <= fsm_d;
            in_hdr_q <= in_hdr_d;
            out_wr   <= pop;
            eop      <= eop_pop;
            if (pop) begin
                out_data <= data_arr[cur_queue];
                out_ctrl <= head_ctrl;
            end
            if (advance && next_found) begin
                cur_queue <= next_q;
                credit_q  <= w_arr[next_q];
            end else if (eop_pop && credit_q != '0) begin
                credit_q <= credit_q - WEIGHT_WIDTH'(1);
            end
        end
    end

    assign state = (fsm_q == PKT);
endmodule

// File: tb/tb_wrr_input_arbiter.sv
// Scoreboard bench: WRR packet-order model feeds expected words; a negedge monitor checks them.
module tb_wrr_input_arbiter;
    import wrr_input_arbiter_pkg::*;
    localparam int DW = DATA_WIDTH_DEF;
    localparam int CW = CTRL_WIDTH_DEF;
    localparam int NQ = NUM_QUEUES_DEF;
    localparam int WW = WEIGHT_WIDTH_DEF;
    localparam int QW = $clog2(NQ);

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          e;
    } word_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NQ*DW-1:0] in_data;
    logic [NQ*CW-1:0] in_ctrl;
    logic [NQ-1:0]    in_empty;
    logic [NQ-1:0]    in_rd_en;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_ctrl;
    logic             out_wr;
    logic             out_rdy = 1'b1;
    logic [NQ*WW-1:0] weights = '0;
    logic [QW-1:0]    cur_queue;
    logic             state;
    logic             eop;

    wrr_input_arbiter dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_empty(in_empty), .in_rd_en(in_rd_en), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .weights(weights), .cur_queue(cur_queue), .state(state), .eop(eop)
    );

    always #5 clk = ~clk;

    word_t fifo[NQ][$];
    word_t stage[NQ][$];
    word_t pk[NQ][$];
    int    plen[NQ][$];
    word_t sb[$];
    int    npk[NQ];
    int    fix_body = 0;
    int    errors = 0;
    int    checks = 0;
    bit    rdy_rand = 0, chk_rst = 0, chk_idle = 0, chk_q_en = 0, chk_rd_en = 0, chk_timeout = 0;
    logic [QW-1:0] chk_q = '0;
    logic [NQ-1:0] chk_rd = '0;

    // Monitor: every output word is matched against the scoreboard head.
    always @(negedge clk) begin : monitor
        word_t exp;
        checks++;
        if (out_wr === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_word: got data=%h ctrl=%h, required no output", out_data, out_ctrl);
            end else begin
                exp = sb.pop_front();
                if (out_data !== exp.d || out_ctrl !== exp.c || eop !== exp.e) begin
                    errors++;
                    $display("FAIL out_word: got data=%h ctrl=%h eop=%b, required data=%h ctrl=%h eop=%b",
                             out_data, out_ctrl, eop, exp.d, exp.c, exp.e);
                end
            end
        end else if (eop !== 1'b0) begin
            errors++;
            $display("FAIL eop_without_wr: got eop=%b out_wr=%b, required eop=0", eop, out_wr);
        end
        if (in_rd_en != '0) begin
            checks++;
            if (!$onehot(in_rd_en) || out_rdy !== 1'b1 || reset) begin
                errors++;
                $display("FAIL rd_en_rule: got rd_en=%b out_rdy=%b reset=%b, required one-hot with out_rdy=1",
                         in_rd_en, out_rdy, reset);
            end
        end
        if (chk_idle) begin
            checks++;
            if (in_rd_en !== '0 || out_wr !== 1'b0) begin
                errors++;
                $display("FAIL stall: got rd_en=%b out_wr=%b, required 0 and 0", in_rd_en, out_wr);
            end
        end
        if (chk_q_en) begin
            checks++;
            if (cur_queue !== chk_q) begin
                errors++;
                $display("FAIL cur_queue: got %0d, required %0d", cur_queue, chk_q);
            end
        end
        if (chk_rd_en) begin
            checks++;
            if (in_rd_en !== chk_rd) begin
                errors++;
                $display("FAIL rd_en_value: got %b, required %b", in_rd_en, chk_rd);
            end
        end
        if (chk_rst) begin
            checks++;
            if (out_wr !== 1'b0 || eop !== 1'b0 || state !== 1'b0 || cur_queue !== '0 ||
                out_data !== '0 || out_ctrl !== '0) begin
                errors++;
                $display("FAIL reset_state: got wr=%b eop=%b state=%b q=%0d data=%h ctrl=%h, required all zero",
                         out_wr, eop, state, cur_queue, out_data, out_ctrl);
            end
        end
        if (chk_timeout) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d words still expected, required 0", sb.size());
        end
    end

    function automatic int wt(input int q);
        return int'(weights[q*WW +: WW]);
    endfunction

    task automatic set_all_w(input int v);
        for (int q = 0; q < NQ; q++) weights[q*WW +: WW] = WW'(v);
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NQ; i++) begin
            if (fifo[i].size() > 0) begin
                in_data[i*DW +: DW] = fifo[i][0].d;
                in_ctrl[i*CW +: CW] = fifo[i][0].c;
                in_empty[i]         = 1'b0;
            end else begin
                in_data[i*DW +: DW] = '0;
                in_ctrl[i*CW +: CW] = '0;
                in_empty[i]         = 1'b1;
            end
        end
    endtask

    // FWFT FIFO model: pops follow the rd_en seen at the edge, inputs change just after it.
    task automatic tick();
        logic [NQ-1:0] rd;
        @(posedge clk);
        rd = in_rd_en;
        #1;
        for (int i = 0; i < NQ; i++)
            if (rd[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        drive_heads();
        if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic gen_pkt(input int q, input int idx, output word_t w[$]);
        int nh, nb;
        word_t x;
        w  = {};
        nh = (fix_body > 0) ? 1 : int'($urandom_range(1, 2));
        nb = (fix_body > 0) ? fix_body : int'($urandom_range(1, 4));
        for (int i = 0; i < nh + nb + 1; i++) begin
            x.d = {8'(q), 8'(idx), 8'(i), 8'h00, 32'($urandom)};
            x.c = (i >= nh && i < nh + nb) ? '0 : CW'($urandom_range(1, 255));
            x.e = (i == nh + nb);
            w.push_back(x);
        end
    endtask

    task automatic clear_all();
        for (int q = 0; q < NQ; q++) begin
            fifo[q].delete(); stage[q].delete(); pk[q].delete(); plen[q].delete();
        end
        sb.delete();
        drive_heads();
    endtask

    task automatic do_reset();
        reset = 1'b1; out_rdy = 1'b1; rdy_rand = 0;
        clear_all();
        tick();
        chk_rst = 1; tick(); chk_rst = 0;
    endtask

    // Reference: each turn a queue sends min(weight, packets left), then the grant
    // moves to the next queue (wrapping, itself last) with packets and nonzero weight.
    task automatic model(input int first);
        int p, n, len, nxt;
        bit found;
        p = first;
        forever begin
            n = (wt(p) < plen[p].size()) ? wt(p) : plen[p].size();
            for (int k = 0; k < n; k++) begin
                len = plen[p].pop_front();
                for (int j = 0; j < len; j++) sb.push_back(pk[p].pop_front());
            end
            found = 0; nxt = p;
            for (int k = 1; k <= NQ; k++) begin
                if (!found && plen[(p + k) % NQ].size() > 0 && wt((p + k) % NQ) > 0) begin
                    found = 1; nxt = (p + k) % NQ;
                end
            end
            if (!found) break;
            p = nxt;
        end
    endtask

    // Only the first queue is non-empty on the first grant, so it wins it; the rest arrive next.
    task automatic setup(input int first);
        word_t w[$];
        do_reset();
        for (int q = 0; q < NQ; q++)
            for (int k = 0; k < npk[q]; k++) begin
                gen_pkt(q, k, w);
                plen[q].push_back(w.size());
                foreach (w[j]) begin pk[q].push_back(w[j]); stage[q].push_back(w[j]); end
            end
        model(first);
        fifo[first] = stage[first];
        drive_heads();
        reset = 1'b0;
        tick();
        for (int q = 0; q < NQ; q++) if (q != first) fifo[q] = stage[q];
        drive_heads();
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb.size() > 0 && cyc < 3000) begin tick(); cyc++; end
        if (sb.size() > 0) begin chk_timeout = 1; tick(); chk_timeout = 0; sb.delete(); end
        rdy_rand = 0; out_rdy = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_word(input int q, input int wi);
        int cyc = 0;
        while (!(out_wr === 1'b1 && out_data[63:56] == 8'(q) && out_data[47:40] == 8'(wi)) && cyc < 200) begin
            tick(); cyc++;
        end
        if (cyc >= 200) begin chk_timeout = 1; tick(); chk_timeout = 0; end
    endtask

    task automatic clear_npk();
        for (int q = 0; q < NQ; q++) npk[q] = 0;
    endtask

    initial begin
        word_t w[$];
        int first;
        clear_all();

        // Equal weights, q0 and q2 with three 4-word packets each: q0,q2,q0,q2,q0,q2.
        set_all_w(1); clear_npk(); npk[0] = 3; npk[2] = 3; fix_body = 2;
        setup(0); drain();

        // q0 weight 3, q1 weight 1: q0,q0,q0,q1 repeating.
        set_all_w(1); weights[0 +: WW] = WW'(3); clear_npk(); npk[0] = 6; npk[1] = 2;
        setup(0); drain();

        // Random weights, backlogs, lengths and backpressure.
        fix_body = 0;
        repeat (4) begin
            for (int q = 0; q < NQ; q++) begin
                weights[q*WW +: WW] = WW'($urandom_range(0, 3));
                npk[q] = $urandom_range(0, 3);
            end
            first = $urandom_range(0, NQ - 1);
            if (wt(first) == 0) weights[first*WW +: WW] = WW'(2);
            if (npk[first] == 0) npk[first] = 2;
            setup(first); rdy_rand = 1; drain();
        end

        // Five-cycle out_rdy stall mid-body: no pops, no writes, grant held on q4.
        set_all_w(1); clear_npk(); npk[4] = 1; npk[5] = 1; fix_body = 6;
        setup(4);
        wait_word(4, 2);
        out_rdy = 1'b0; chk_rd_en = 1; chk_rd = '0; chk_q_en = 1; chk_q = QW'(4);
        tick();
        chk_rd_en = 0; chk_idle = 1;
        repeat (4) tick();
        chk_idle = 0; chk_q_en = 0; out_rdy = 1'b1;
        drain();

        // Wrap-around: grant sits on q7, then only q1 fills -> grant 1, pop the cycle after.
        clear_npk(); npk[7] = 1; fix_body = 2;
        setup(7); drain();
        chk_q_en = 1; chk_q = QW'(7); tick(); chk_q_en = 0;
        gen_pkt(1, 0, w);
        foreach (w[j]) begin fifo[1].push_back(w[j]); sb.push_back(w[j]); end
        drive_heads();
        tick();
        chk_q_en = 1; chk_q = QW'(1); chk_rd_en = 1; chk_rd = NQ'(2);
        tick();
        chk_q_en = 0; chk_rd_en = 0;
        drain();

        // Zero-weight queue with data, all others empty: nothing moves.
        set_all_w(1); weights[3*WW +: WW] = '0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            gen_pkt(3, k, w);
            foreach (w[j]) fifo[3].push_back(w[j]);
        end
        drive_heads();
        reset = 1'b0;
        chk_idle = 1; repeat (20) tick(); chk_idle = 0;

        // Reset while body word 2 of a q2 packet is on the output.
        set_all_w(1); clear_npk(); npk[2] = 1; fix_body = 6;
        setup(2);
        wait_word(2, 2);
        reset = 1'b1;
        tick();
        chk_rst = 1; tick(); chk_rst = 0;
        clear_all(); reset = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wrr_input_arbiter.md
WRR_INPUT_ARBITER -- requirements
Module: wrr_input_arbiter

Interface
REQ-001 Parameters: DATA_WIDTH 64 (bus data width); CTRL_WIDTH DATA_WIDTH/8 (ctrl width); NUM_QUEUES 8 (input queues); WEIGHT_WIDTH 4 (per-queue packet quantum width).
REQ-002 clk  in  1  clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_data  in  NUM_QUEUES*DATA_WIDTH  head word of each first-word-fall-through input FIFO; queue i in slice i.
REQ-005 in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  head ctrl of each input FIFO.
REQ-006 in_empty  in  NUM_QUEUES  FIFO empty flags; head word is valid when low.
REQ-007 in_rd_en  out  NUM_QUEUES  pop strobe per FIFO, combinational, at most one bit high.
REQ-008 out_data / out_ctrl  out  DATA_WIDTH / CTRL_WIDTH  registered output word.
REQ-009 out_wr  out  1  registered output write strobe.
REQ-010 out_rdy  in  1  downstream can accept a word this cycle.
REQ-011 weights  in  NUM_QUEUES*WEIGHT_WIDTH  packets per turn for each queue; 0 excludes the queue.
REQ-012 cur_queue  out  log2(NUM_QUEUES)  queue currently granted.
REQ-013 state  out  1  high while a packet is in transfer (PKT state).
REQ-014 eop  out  1  one-cycle pulse, coincident with out_wr of a packet's last word.

Function
REQ-015 Packet framing: one or more header words (ctrl!=0), then body words (ctrl==0), then a final word (ctrl!=0) after at least one body word, which is the EOP word.
REQ-016 FSM states: IDLE and PKT. In IDLE, a word whose ctrl==0 at the head of the granted queue moves the FSM to PKT. In PKT, popping the EOP word returns the FSM to IDLE.
REQ-017 Pop condition: in_rd_en[cur_queue] = !in_empty[cur_queue] && out_rdy && weights[cur_queue]!=0; no other bit is ever asserted.
REQ-018 A popped word appears on out_data/out_ctrl with out_wr=1 exactly one cycle after in_rd_en; otherwise out_wr=0 and out_data/out_ctrl hold their values.
REQ-019 A credit counter (WEIGHT_WIDTH bits) loads weights[q] when queue q is granted and decrements by 1 at each EOP pop.
REQ-020 The grant advances only at a packet boundary, i.e. in IDLE with no word of a new packet yet popped, when either condition holds:
  - credit == 0; or
  - the granted queue is empty.
REQ-021 The next grant is the first queue after cur_queue, in rotating order with wrap-around from NUM_QUEUES-1 to 0, that is non-empty and has a nonzero weight. If no queue qualifies, the grant is unchanged and no pop occurs.
REQ-022 Advancing the grant takes one cycle, with no pop in that cycle; popping from the new queue may begin the following cycle.
REQ-023 Boundary conditions:
  - Mid-packet empty or out_rdy low: stall on the same queue; never switch mid-packet.
  - Only one eligible queue: it is re-granted with a fresh credit load.
  - Weight changes take effect at the next credit load only.
REQ-024 Throughput: one word per cycle while the FIFO is non-empty and out_rdy is high.

Reset
REQ-025 On reset, the following values are forced on the next edge:
  - FSM = IDLE, cur_queue = 0, credit = 0, out_wr = 0, eop = 0, out_data = 0, out_ctrl = 0.
  - in_rd_en is low while reset is asserted.
REQ-026 Reset mid-packet abandons the packet without flushing FIFOs; upstream is responsible for FIFO resynchronisation.

Structure
REQ-027 The shared package holds the defaults for DATA_WIDTH, CTRL_WIDTH, NUM_QUEUES and WEIGHT_WIDTH, and the FSM state encoding (IDLE=0, PKT=1).
REQ-028 The rotating next-queue selection is implemented in one sub-module, rr_next_sel (inputs: eligibility vector and current index; output: next index and found flag).

Verification
REQ-029 Equal weights: all weights=1, queues 0 and 2 each hold three 4-word packets -> output order q0,q2,q0,q2,q0,q2 and eop pulses 6.
REQ-030 Weighted: weights q0=3, q1=1, both backlogged -> output order q0,q0,q0,q1, repeating.
REQ-031 Backpressure: deassert out_rdy for 5 cycles mid-body -> no pop and out_wr=0 during the stall; the packet resumes intact with no queue switch.
REQ-032 Wrap-around: cur_queue=7, only queue 1 non-empty -> next grant is 1, and the first pop occurs 1 cycle after the advance.
REQ-033 Zero weight: weights q3=0, q3 non-empty, all others empty -> in_rd_en stays 0 and out_wr stays 0.
REQ-034 Reset mid-packet: assert reset during body word 2 -> next cycle out_wr=0, state=0, cur_queue=0.
